dcache_writeback_buffer: RTL and testbench

//  Parametrised multi-entry write-back (victim) buffer between dcache and AXI bridge, on the line-write path.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/wb_cam_lookup.sv | 34 +++
 rtl/dcache_writeback_buffer.sv | 194 +++++++++++++++++++
 tb/tb_dcache_writeback_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared dcache line-path types and constants.
// Line geometry, write-back entry layout and drain FSM states.
package cache_pkg;

  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = 32 * LINE_WORDS;
  localparam int OFF_W      = $clog2(LINE_WORDS * 4);
  localparam int ADDR_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } wb_state_e;

  typedef struct packed {
    logic                    valid;
    logic [ADDR_W-OFF_W-1:0] tag;
    logic [LINE_W-1:0]       data;
  } wb_entry_t;

  function automatic logic [ADDR_W-1:0] line_align(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/wb_cam_lookup.sv
// DEPTH-way line-tag compare over the write-back FIFO.
// Among matching entries the youngest (nearest tail) wins.
module wb_cam_lookup #(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = 28,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            valid_i,
  input  logic [DEPTH-1:0][TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0]            key_i,
  input  logic [DEPTH-1:0]            mask_i,
  input  logic [PTR_W-1:0]            oldest_i,
  output logic                        hit_o,
  output logic [PTR_W-1:0]            idx_o
);

  logic [PTR_W-1:0] slot;

  // Walk oldest to youngest so a later match overrides an older one
  always_comb begin
    hit_o = 1'b0;
    idx_o = oldest_i;
    slot  = oldest_i;
    for (int k = 0; k < DEPTH; k++) begin
      slot = oldest_i + PTR_W'(k);
      if (valid_i[slot] && !mask_i[slot] &&
          tag_i[slot] == key_i) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end

endmodule

// File: rtl/dcache_writeback_buffer.sv
// Victim buffer between dcache and the AXI line-write bridge.
// FIFO of dirty lines with in-place merge and refill forwarding.
module dcache_writeback_buffer #(
  parameter  int DEPTH      = 4,
  parameter  int LINE_WORDS = cache_pkg::LINE_WORDS,
  parameter  int ADDR_W     = cache_pkg::ADDR_W,
  localparam int LINE_W     = 32 * LINE_WORDS
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              c_wr_req,
  input  logic [ADDR_W-1:0] c_wr_addr,
  input  logic [LINE_W-1:0] c_wr_data,
  output logic              c_wr_rdy,
  input  logic [ADDR_W-1:0] c_rd_addr,
  output logic              c_rd_hit,
  output logic [LINE_W-1:0] c_rd_data,
  output logic              empty,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LINE_W-1:0] wr_data,
  input  logic              wr_rdy,
  input  logic              wr_valid
);

  import cache_pkg::wb_state_e;
  import cache_pkg::IDLE;
  import cache_pkg::REQ;
  import cache_pkg::WAIT;

  localparam int OFF_W = $clog2(LINE_WORDS * 4);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][TAG_W-1:0]  tag_q;
  logic [DEPTH-1:0][LINE_W-1:0] data_q;

  logic [CNT_W-1:0] head_q, head_d;
  logic [CNT_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  wb_state_e         state_q;
  logic              wr_req_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [LINE_W-1:0] wr_data_q;

  logic [PTR_W-1:0] head_idx;
  logic [PTR_W-1:0] tail_idx;
  logic [PTR_W-1:0] mrg_idx;
  logic [PTR_W-1:0] rd_idx;
  logic [TAG_W-1:0] wr_tag;
  logic [TAG_W-1:0] rd_tag;
  logic [DEPTH-1:0] excl;
  logic [DEPTH-1:0] no_mask;

  logic in_flight;
  logic mrg_hit;
  logic rd_hit;
  logic push;
  logic merge;
  logic alloc;
  logic pop;
  logic head_merge;
  logic unused_addr_bits;

  assign head_idx  = head_q[PTR_W-1:0];
  assign tail_idx  = tail_q[PTR_W-1:0];
  assign wr_tag    = c_wr_addr[ADDR_W-1:OFF_W];
  assign rd_tag    = c_rd_addr[ADDR_W-1:OFF_W];
  assign in_flight = (state_q != IDLE);
  assign excl      = in_flight ? (DEPTH'(1) << head_idx)
                               : '0;
  assign no_mask   = '0;

  assign unused_addr_bits = ^{c_wr_addr[OFF_W-1:0],
                              c_rd_addr[OFF_W-1:0]};

  wb_cam_lookup #(
    .DEPTH(DEPTH),
    .TAG_W(TAG_W)
  ) u_merge_cam (
    .valid_i (valid_q),
    .tag_i   (tag_q),
    .key_i   (wr_tag),
    .mask_i  (excl),
    .oldest_i(head_idx),
    .hit_o   (mrg_hit),
    .idx_o   (mrg_idx)
  );

  wb_cam_lookup #(
    .DEPTH(DEPTH),
    .TAG_W(TAG_W)
  ) u_rd_cam (
    .valid_i (valid_q),
    .tag_i   (tag_q),
    .key_i   (rd_tag),
    .mask_i  (no_mask),
    .oldest_i(head_idx),
    .hit_o   (rd_hit),
    .idx_o   (rd_idx)
  );

  assign c_wr_rdy   = (count_q != CNT_W'(DEPTH));
  assign push       = c_wr_req && c_wr_rdy;
  assign merge      = push && mrg_hit;
  assign alloc      = push && !mrg_hit;
  assign pop        = (state_q == WAIT) && wr_valid;
  assign head_merge = merge && (mrg_idx == head_idx);

  // Pointer and occupancy next-state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (alloc) tail_d = tail_q + CNT_W'(1);
    if (pop)   head_d = head_q + CNT_W'(1);
    if (alloc && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !alloc)
      count_d = count_q - CNT_W'(1);
  end

  // Entry storage: allocate at tail, merge in place, retire head
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop)
        valid_q[head_idx] <= 1'b0;
      if (alloc) begin
        valid_q[tail_idx] <= 1'b1;
        tag_q[tail_idx]   <= wr_tag;
        data_q[tail_idx]  <= c_wr_data;
      end
      if (merge)
        data_q[mrg_idx] <= c_wr_data;
    end
  end

  // Drain FSM: snapshot head, hold request, await completion
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q   <= REQ;
            wr_req_q  <= 1'b1;
            wr_addr_q <= {tag_q[head_idx],
                          {OFF_W{1'b0}}};
            wr_data_q <= head_merge ? c_wr_data
                                    : data_q[head_idx];
          end
        end
        REQ: begin
          if (wr_rdy) begin
            state_q  <= WAIT;
            wr_req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (wr_valid) state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          wr_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_req    = wr_req_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign c_rd_hit  = rd_hit;
  assign c_rd_data = rd_hit ? data_q[rd_idx] : '0;
  assign empty     = (count_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_dcache_writeback_buffer.sv
// Directed bench for the dcache write-back buffer.
// Expected AXI writes are queued at stimulus and popped by a monitor.
module tb_dcache_writeback_buffer;

  logic         clk = 1'b0;
  logic         resetn;
  logic         c_wr_req;
  logic [31:0]  c_wr_addr;
  logic [127:0] c_wr_data;
  logic         c_wr_rdy;
  logic [31:0]  c_rd_addr;
  logic         c_rd_hit;
  logic [127:0] c_rd_data;
  logic         empty;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         wr_valid;
  logic         br_valid;
  logic         man_valid;

  typedef struct packed {
    logic [31:0]  a;
    logic [127:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t e_mon;
  int  n_chk = 0;
  int  n_fail = 0;
  int  req_cyc = 0;
  int  n_done = 0;
  bit  auto_br = 1'b0;
  int  br_lat = 1;

  localparam logic [127:0] D0 = 128'h0303_0303_0202_0202_0101_0101_0000_0000;
  localparam logic [127:0] D1 = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
  localparam logic [127:0] D2 = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
  localparam logic [127:0] D3 = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
  localparam logic [127:0] D4 = 128'h4444_4444_4444_4444_4444_4444_4444_4444;
  localparam logic [127:0] D5 = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
  localparam logic [127:0] D6 = 128'h6666_6666_6666_6666_6666_6666_6666_6666;

  assign wr_valid = br_valid | man_valid;

  always #5 clk = ~clk;

  dcache_writeback_buffer dut (
    .clk      (clk),
    .resetn   (resetn),
    .c_wr_req (c_wr_req),
    .c_wr_addr(c_wr_addr),
    .c_wr_data(c_wr_data),
    .c_wr_rdy (c_wr_rdy),
    .c_rd_addr(c_rd_addr),
    .c_rd_hit (c_rd_hit),
    .c_rd_data(c_rd_data),
    .empty    (empty),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .wr_valid (wr_valid)
  );

  task automatic chk1(string nm, logic got, logic want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic chka(string nm, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic chkd(string nm, logic [127:0] got, logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Scoreboard monitor: every accepted AXI request must match the queue head
  always @(negedge clk) begin
    if (resetn && wr_req) req_cyc++;
    if (resetn && wr_valid) n_done++;
    if (resetn && wr_req && wr_rdy) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h want none", wr_addr, wr_data);
      end else begin
        e_mon = exp_q.pop_front();
        chka("wr_addr", wr_addr, e_mon.a);
        chkd("wr_data", wr_data, e_mon.d);
      end
    end
  end

  // Bridge model: completion pulse br_lat cycles after acceptance
  initial begin
    br_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_br && resetn && wr_req && wr_rdy) begin
        repeat (br_lat) @(posedge clk);
        #1 br_valid = 1'b1;
        @(posedge clk);
        #1 br_valid = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no summary want summary");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(logic [31:0] a, logic [127:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic push(logic [31:0] a, logic [127:0] d);
    int n = 0;
    c_wr_req  = 1'b1;
    c_wr_addr = a;
    c_wr_data = d;
    while (!c_wr_rdy && n < 200) begin
      step();
      n++;
    end
    chk1("push_accept", c_wr_rdy, 1'b1);
    step();
    c_wr_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !empty) && n < 300) begin
      step();
      n++;
    end
    chk1("drain_done", (exp_q.size() == 0) && empty, 1'b1);
  endtask

  task automatic lookup(string nm, logic [31:0] a, logic hit, logic [127:0] d);
    c_rd_addr = a;
    #1;
    chk1({nm, "_hit"}, c_rd_hit, hit);
    chkd({nm, "_data"}, c_rd_data, d);
  endtask

  initial begin
    resetn    = 1'b0;
    c_wr_req  = 1'b0;
    c_wr_addr = '0;
    c_wr_data = '0;
    c_rd_addr = '0;
    wr_rdy    = 1'b0;
    man_valid = 1'b0;
    repeat (3) step();

    // Reset state
    chk1("rst_wr_req", wr_req, 1'b0);
    chka("rst_wr_addr", wr_addr, 32'h0);
    chkd("rst_wr_data", wr_data, 128'h0);
    chk1("rst_rd_hit", c_rd_hit, 1'b0);
    chk1("rst_wr_rdy", c_wr_rdy, 1'b1);
    chk1("rst_empty", empty, 1'b1);
    resetn = 1'b1;
    step();

    // 1: single line, bridge ready, completion two cycles later
    auto_br = 1'b1;
    br_lat  = 2;
    wr_rdy  = 1'b1;
    req_cyc = 0;
    expect_wr(32'h1000_0040, D0);
    push(32'h1000_0040, D0);
    drain();
    chka("t1_req_cycles", 32'(req_cyc), 32'd1);

    // 2: fill while bridge stalls, 5th push held off
    br_lat = 1;
    wr_rdy = 1'b0;
    n_done = 0;
    expect_wr(32'h2000, D1);
    expect_wr(32'h2010, D2);
    expect_wr(32'h2020, D3);
    expect_wr(32'h2030, D4);
    expect_wr(32'h2040, D5);
    push(32'h2000, D1);
    push(32'h2010, D2);
    push(32'h2020, D3);
    push(32'h2030, D4);
    chk1("t2_full_rdy", c_wr_rdy, 1'b0);
    chk1("t2_req_held", wr_req, 1'b1);
    chka("t2_req_addr", wr_addr, 32'h2000);
    c_wr_req  = 1'b1;
    c_wr_addr = 32'h2040;
    c_wr_data = D5;
    repeat (3) step();
    chk1("t2_held_off", c_wr_rdy, 1'b0);
    wr_rdy = 1'b1;
    for (int n = 0; n < 50 && !c_wr_rdy; n++) step();
    chka("t2_done_at_rdy", 32'(n_done), 32'd1);
    push(32'h2040, D5);
    drain();

    // 3: merge into a queued non-head line, low offset bits ignored
    wr_rdy = 1'b0;
    expect_wr(32'h0080, D1);
    expect_wr(32'h0100, D3);
    expect_wr(32'h0180, D5);
    expect_wr(32'h0200, D6);
    push(32'h0080, D1);
    push(32'h0100, D2);
    push(32'h010C, D3);
    lookup("t3_merged", 32'h0000_0104, 1'b1, D3);
    chk1("t3_cnt2_rdy", c_wr_rdy, 1'b1);
    push(32'h0180, D5);
    chk1("t3_cnt3_rdy", c_wr_rdy, 1'b1);
    push(32'h0200, D6);
    chk1("t3_cnt4_rdy", c_wr_rdy, 1'b0);
    chka("t3_head_addr", wr_addr, 32'h0080);
    wr_rdy = 1'b1;
    drain();

    // 4: rewrite of the in-flight head allocates a fresh entry
    auto_br = 1'b0;
    expect_wr(32'h0080, D1);
    expect_wr(32'h0080, D4);
    push(32'h0080, D1);
    step();
    step();
    chk1("t4_wait_req", wr_req, 1'b0);
    chk1("t4_wait_empty", empty, 1'b0);
    lookup("t4_inflight", 32'h0000_0080, 1'b1, D1);
    push(32'h0080, D4);
    lookup("t4_young", 32'h0000_0084, 1'b1, D4);
    lookup("t4_miss", 32'h0000_0090, 1'b0, 128'h0);
    auto_br   = 1'b1;
    man_valid = 1'b1;
    step();
    man_valid = 1'b0;
    lookup("t4_after_pop", 32'h0000_0080, 1'b1, D4);
    drain();

    // 5: full with push and completion together, push is refused
    auto_br = 1'b0;
    expect_wr(32'h0300, D1);
    expect_wr(32'h0310, D2);
    expect_wr(32'h0320, D3);
    expect_wr(32'h0330, D4);
    expect_wr(32'h0350, D6);
    push(32'h0300, D1);
    push(32'h0310, D2);
    push(32'h0320, D3);
    push(32'h0330, D4);
    chk1("t5_full", c_wr_rdy, 1'b0);
    c_wr_req  = 1'b1;
    c_wr_addr = 32'h0340;
    c_wr_data = D5;
    man_valid = 1'b1;
    step();
    c_wr_req  = 1'b0;
    man_valid = 1'b0;
    chk1("t5_rdy_after_pop", c_wr_rdy, 1'b1);
    push(32'h0350, D6);
    chk1("t5_refull", c_wr_rdy, 1'b0);
    man_valid = 1'b1;
    step();
    man_valid = 1'b0;
    chk1("t5_valid_in_req", c_wr_rdy, 1'b0);
    man_valid = 1'b1;
    step();
    man_valid = 1'b0;
    chk1("t5_valid_in_wait", c_wr_rdy, 1'b1);
    auto_br = 1'b1;
    drain();

    // 6: reset while a request is pending
    auto_br = 1'b0;
    wr_rdy  = 1'b0;
    push(32'h0400, D1);
    push(32'h0410, D2);
    push(32'h0420, D3);
    chk1("t6_req_pending", wr_req, 1'b1);
    lookup("t6_pre_hit", 32'h0000_0410, 1'b1, D2);
    resetn = 1'b0;
    #1;
    chk1("t6_rst_req", wr_req, 1'b0);
    chk1("t6_rst_empty", empty, 1'b1);
    chk1("t6_rst_hit", c_rd_hit, 1'b0);
    chk1("t6_rst_rdy", c_wr_rdy, 1'b1);
    step();
    step();
    resetn  = 1'b1;
    wr_rdy  = 1'b1;
    req_cyc = 0;
    repeat (10) step();
    chka("t6_no_stale", 32'(req_cyc), 32'd0);
    chk1("t6_post_empty", empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
